// File: rtl/emc_arb.sv
// emc_arb: external-bus arbiter for core, ECM and byte-DMA with external bus-request hold
// Ports:
//   DSPCLK, T_RSTn                clock, asynchronous active-low reset
//   CORE_req, ECM_req, BDMA_req   internal access requests (level)
//   CYC_end                       one-cycle pulse, current external bus cycle done
//   BRn                           external bus request, active-low, asynchronous
//   CORE_gnt, ECM_gnt, BDMA_gnt   registered, mutually exclusive grants
//   BGn, BGHn                     registered bus grant / bus-grant-hang, active-low
//   OWNER                         registered owner code: 00 none, 01 core, 10 ECM, 11 BDMA
module emc_arb (
  input  logic       DSPCLK,
  input  logic       T_RSTn,
  input  logic       CORE_req,
  input  logic       ECM_req,
  input  logic       BDMA_req,
  input  logic       CYC_end,
  input  logic       BRn,
  output logic       CORE_gnt,
  output logic       ECM_gnt,
  output logic       BDMA_gnt,
  output logic       BGn,
  output logic       BGHn,
  output logic [1:0] OWNER
);
  typedef enum logic [2:0] {S_IDLE, S_OWN, S_TURN, S_HOLD, S_RLS} state_t;
  state_t     r_state;
  logic       r_sync1, r_sync2;
  logic [3:0] r_starve;
  logic       w_br_s, w_any, w_arb, w_starved, w_bgn_nxt;
  logic [1:0] w_win;
  always_ff @(posedge DSPCLK or negedge T_RSTn)
    if (!T_RSTn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= BRn;
      r_sync2 <= r_sync1;
    end
  assign w_br_s    = !r_sync2;
  assign w_any     = CORE_req | ECM_req | BDMA_req;
  assign w_arb     = (r_state == S_IDLE) || (r_state == S_TURN);
  // a starved BDMA only wins while it is still asking
  assign w_starved = (r_starve == 4'd15) && BDMA_req;
  assign w_win     = w_starved ? 2'b11 : CORE_req ? 2'b01 : ECM_req ? 2'b10 : 2'b11;
  // bus is handed out (or kept) only from the arbitration points or while holding
  assign w_bgn_nxt = !(w_br_s && (w_arb || r_state == S_HOLD));
  always_ff @(posedge DSPCLK or negedge T_RSTn)
    if (!T_RSTn)
      r_starve <= 4'd0;
    else if (!BDMA_req || BDMA_gnt)
      r_starve <= 4'd0;
    else if (r_starve != 4'd15)
      r_starve <= r_starve + 4'd1;
  always_ff @(posedge DSPCLK or negedge T_RSTn)
    if (!T_RSTn) begin
      r_state  <= S_IDLE;
      OWNER    <= 2'b00;
      CORE_gnt <= 1'b0;
      ECM_gnt  <= 1'b0;
      BDMA_gnt <= 1'b0;
      BGn      <= 1'b1;
      BGHn     <= 1'b1;
    end else begin
      BGn  <= w_bgn_nxt;
      BGHn <= w_bgn_nxt || !w_any;
      case (r_state)
        S_IDLE, S_TURN:
          if (w_br_s)
            r_state <= S_HOLD;
          else if (w_any) begin
            r_state  <= S_OWN;
            OWNER    <= w_win;
            CORE_gnt <= (w_win == 2'b01);
            ECM_gnt  <= (w_win == 2'b10);
            BDMA_gnt <= (w_win == 2'b11);
          end else
            r_state <= S_IDLE;
        S_OWN:
          if (CYC_end) begin
            r_state  <= S_TURN;
            OWNER    <= 2'b00;
            CORE_gnt <= 1'b0;
            ECM_gnt  <= 1'b0;
            BDMA_gnt <= 1'b0;
          end
        S_HOLD:
          if (!w_br_s)
            r_state <= S_RLS;
        S_RLS:
          r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_emc_arb.sv
// tb_emc_arb: directed and randomized checks of emc_arb against a behavioural model
module tb_emc_arb;
  logic       DSPCLK = 1'b0;
  logic       T_RSTn = 1'b0;
  logic       CORE_req = 1'b0, ECM_req = 1'b0, BDMA_req = 1'b0, CYC_end = 1'b0, BRn = 1'b1;
  logic       CORE_gnt, ECM_gnt, BDMA_gnt, BGn, BGHn;
  logic [1:0] OWNER;
  int total = 0;
  int bad = 0;
  localparam int P_IDLE = 0, P_OWN = 1, P_TURN = 2, P_HOLD = 3, P_RLS = 4;
  int         m_phase, m_wait;
  logic [1:0] m_owner;
  logic       m_bg, m_bgh;
  logic       br_d1, br_d2;
  logic       saw_bdma;
  emc_arb dut (
    .DSPCLK(DSPCLK), .T_RSTn(T_RSTn), .CORE_req(CORE_req), .ECM_req(ECM_req),
    .BDMA_req(BDMA_req), .CYC_end(CYC_end), .BRn(BRn), .CORE_gnt(CORE_gnt),
    .ECM_gnt(ECM_gnt), .BDMA_gnt(BDMA_gnt), .BGn(BGn), .BGHn(BGHn), .OWNER(OWNER)
  );
  always #5 DSPCLK = ~DSPCLK;
  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic mreset();
    m_phase = P_IDLE;
    m_owner = 2'd0;
    m_wait  = 0;
    m_bg    = 1'b1;
    m_bgh   = 1'b1;
    br_d1   = 1'b1;
    br_d2   = 1'b1;
  endtask
  // one rising edge of the reference: rules applied to the inputs sampled at that edge
  task automatic mstep();
    logic brs, any;
    int nw;
    brs   = !br_d2;
    br_d2 = br_d1;
    br_d1 = BRn;
    any   = CORE_req | ECM_req | BDMA_req;
    nw    = (!BDMA_req || m_owner == 2'd3) ? 0 : (m_wait < 15 ? m_wait + 1 : 15);
    if (m_phase == P_IDLE || m_phase == P_TURN) begin
      if (brs) begin
        m_phase = P_HOLD;
        m_bg = 1'b0;
      end else if (any) begin
        m_phase = P_OWN;
        m_owner = (m_wait == 15 && BDMA_req) ? 2'd3 : CORE_req ? 2'd1 : ECM_req ? 2'd2 : 2'd3;
      end else
        m_phase = P_IDLE;
    end else if (m_phase == P_OWN) begin
      if (CYC_end) begin
        m_phase = P_TURN;
        m_owner = 2'd0;
      end
    end else if (m_phase == P_HOLD) begin
      if (!brs) begin
        m_phase = P_RLS;
        m_bg = 1'b1;
      end
    end else
      m_phase = P_IDLE;
    m_wait = nw;
    m_bgh  = !(!m_bg && any);
  endtask
  task automatic check_all();
    chk("OWNER", OWNER, m_owner);
    chk("CORE_gnt", {1'b0, CORE_gnt}, {1'b0, m_owner == 2'd1});
    chk("ECM_gnt", {1'b0, ECM_gnt}, {1'b0, m_owner == 2'd2});
    chk("BDMA_gnt", {1'b0, BDMA_gnt}, {1'b0, m_owner == 2'd3});
    chk("BGn", {1'b0, BGn}, {1'b0, m_bg});
    chk("BGHn", {1'b0, BGHn}, {1'b0, m_bgh});
  endtask
  task automatic tick();
    @(posedge DSPCLK);
    if (!T_RSTn) mreset(); else mstep();
    #1;
    check_all();
  endtask
  task automatic pulse_rst();
    #2 T_RSTn = 1'b0;
    #1 mreset();
    check_all();
    chk("rst_core_gnt", {1'b0, CORE_gnt}, 2'd0);
    chk("rst_owner", OWNER, 2'd0);
    @(negedge DSPCLK) T_RSTn = 1'b1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    mreset();
    #13;
    check_all();
    chk("reset_BGn", {1'b0, BGn}, 2'd1);
    chk("reset_BGHn", {1'b0, BGHn}, 2'd1);
    tick();
    @(negedge DSPCLK) T_RSTn = 1'b1;
    // all three request from idle: CORE, ECM, BDMA with dead cycles between
    {CORE_req, ECM_req, BDMA_req} = 3'b111;
    tick(); chk("seq_core", OWNER, 2'b01);
    ticks(2);
    CYC_end = 1'b1;
    tick(); chk("seq_dead1", OWNER, 2'b00);
    CYC_end = 1'b0; CORE_req = 1'b0;
    tick(); chk("seq_ecm", OWNER, 2'b10);
    CYC_end = 1'b1;
    tick(); chk("seq_dead2", OWNER, 2'b00);
    CYC_end = 1'b0; ECM_req = 1'b0;
    tick(); chk("seq_bdma", OWNER, 2'b11);
    CYC_end = 1'b1;
    tick();
    CYC_end = 1'b0; BDMA_req = 1'b0;
    ticks(2);
    // external request during core ownership must wait for the turn
    CORE_req = 1'b1;
    tick(); chk("br_core_own", OWNER, 2'b01);
    BRn = 1'b0;
    ticks(4);
    chk("br_no_preempt", {1'b0, CORE_gnt}, 2'd1);
    CYC_end = 1'b1; CORE_req = 1'b0;
    tick(); chk("br_turn_bgn", {1'b0, BGn}, 2'd1);
    CYC_end = 1'b0;
    tick(); chk("br_hold_bgn", {1'b0, BGn}, 2'd0);
    ECM_req = 1'b1;
    tick(); chk("hang_low", {1'b0, BGHn}, 2'd0);
    ECM_req = 1'b0;
    tick(); chk("hang_high", {1'b0, BGHn}, 2'd1);
    CYC_end = 1'b1;
    tick(); chk("hold_cyc_ignored", {1'b0, BGn}, 2'd0);
    CYC_end = 1'b0; BRn = 1'b1;
    ticks(4);
    chk("rls_bgn", {1'b0, BGn}, 2'd1);
    // synchroniser latency from idle
    CYC_end = 1'b1;
    tick(); chk("idle_cyc_ignored", OWNER, 2'b00);
    CYC_end = 1'b0; BRn = 1'b0;
    tick(); chk("lat_e1", {1'b0, BGn}, 2'd1);
    tick(); chk("lat_e2", {1'b0, BGn}, 2'd1);
    tick(); chk("lat_e3", {1'b0, BGn}, 2'd0);
    BRn = 1'b1;
    ticks(5);
    // BDMA starvation behind a continuously requesting core
    saw_bdma = 1'b0;
    {CORE_req, BDMA_req} = 2'b11;
    for (int i = 0; i < 45; i++) begin
      CYC_end = (i % 3 == 2);
      tick();
      if (BDMA_gnt) saw_bdma = 1'b1;
    end
    chk("starved_bdma_granted", {1'b0, saw_bdma}, 2'd1);
    {CORE_req, BDMA_req, CYC_end} = 3'b000;
    ticks(4);
    // reset while core owns the bus
    CORE_req = 1'b1;
    tick(); chk("pre_rst_core", OWNER, 2'b01);
    pulse_rst();
    CORE_req = 1'b0;
    tick();
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      CORE_req = ($urandom_range(0, 9) < 4);
      ECM_req  = ($urandom_range(0, 9) < 3);
      BDMA_req = ($urandom_range(0, 9) < 6);
      CYC_end  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) BRn = ~BRn;
      if ($urandom_range(0, 99) == 0) pulse_rst();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/emc_arb.md
EMC_ARB -- requirements
Module: emc_arb

Interface
REQ-001 DSPCLK  input  1  system clock; all flops rising-edge.
REQ-002 T_RSTn  input  1  reset, asynchronous, active-low.
REQ-003 One clock (DSPCLK); reset T_RSTn is asynchronous and active-low.
REQ-004 CORE_req  input  1  core external PM/DM/IO access request; level, held until its cycle ends.
REQ-005 ECM_req  input  1  external cache-memory access request; level.
REQ-006 BDMA_req  input  1  byte-DMA request; level.
REQ-007 CYC_end  input  1  one-cycle pulse from the external memory controller; the current external bus cycle completes.
REQ-008 BRn  input  1  external bus request, active-low, asynchronous to DSPCLK.
REQ-009 CORE_gnt / ECM_gnt / BDMA_gnt  output  1 each  registered grants, mutually exclusive.
REQ-010 BGn  output  1  bus grant to the external master, active-low, registered.
REQ-011 BGHn  output  1  bus-grant-hang, active-low, registered: BGn is low and an internal request is pending.
REQ-012 OWNER  output  2  00 none, 01 core, 10 ECM, 11 BDMA; registered, always consistent with the grants.

Function
REQ-013 BRn SHALL pass through a 2-flop synchroniser (reset value 1); only the synchronised BR_s (=!sync2) is used.
REQ-014 FSM states SHALL be IDLE, OWN, TURN, HOLD, RLS; encoding is free.
REQ-015 IDLE/TURN arbitration priority SHALL be: BR_s > starved BDMA > CORE > ECM > BDMA.
REQ-016 IDLE or TURN with BR_s=1 SHALL go to HOLD; BGn goes low on that edge.
REQ-017 IDLE or TURN with BR_s=0 and any request SHALL go to OWN; the winner's grant and OWNER update on that edge.
REQ-018 IDLE or TURN with no request SHALL go to IDLE.
REQ-019 OWN SHALL hold the grant until CYC_end=1, then go to TURN, clearing all grants and OWNER on that edge.
REQ-020 In OWN, a requester dropping its req without CYC_end SHALL NOT remove its grant.
REQ-021 In OWN, BR_s=1 SHALL NOT preempt; the external master waits for TURN.
REQ-022 TURN SHALL last exactly one cycle with all grants low, so back-to-back owners are separated by one dead cycle.
REQ-023 HOLD SHALL keep BGn=0 and all internal grants 0 while BR_s=1; BR_s=0 SHALL go to RLS with BGn=1.
REQ-024 RLS SHALL last one cycle with no grants, then go to IDLE.
REQ-025 BGHn SHALL be 0 exactly during cycles in which BGn=0 and (CORE_req|ECM_req|BDMA_req) was 1 at the previous edge.
REQ-026 Starvation counter (4 bits): +1 each cycle BDMA_req=1 and BDMA_gnt=0; saturates at 15; cleared to 0 when BDMA is granted or BDMA_req=0.
REQ-027 A counter value of 15 SHALL flag BDMA as starved; the starved flag does not override BR_s.
REQ-028 CYC_end outside OWN SHALL be ignored.
REQ-029 Grant latency: a request sampled at an IDLE edge SHALL be granted from that edge.
REQ-030 BRn going low while idle SHALL give BGn=0 at the 3rd DSPCLK edge after BRn is first low at a sampling edge.

Reset
REQ-031 T_RSTn=0 SHALL asynchronously force state IDLE; all grants 0; OWNER=00; BGn=1; BGHn=1; counter 0; synchroniser flops 1.
REQ-032 Reset asserted mid-OWN or mid-HOLD SHALL drop grants/BGn immediately, without waiting for CYC_end.
REQ-033 After T_RSTn rises, the first arbitration SHALL occur at the next DSPCLK edge.

Verification
REQ-034 CORE_req=ECM_req=BDMA_req=1 from IDLE -> order CORE, ECM, BDMA, each ended by CYC_end, with one dead cycle between grants; OWNER sequence 01,00,10,00,11.
REQ-035 BRn low during core OWN -> no preemption; after CYC_end: TURN, then HOLD with BGn=0; BRn high -> RLS, then IDLE.
REQ-036 CORE_req held high continuously with BDMA_req=1 -> counter reaches 15, and BDMA is granted at the next TURN/IDLE arbitration ahead of CORE.
REQ-037 In HOLD with ECM_req=1 -> BGHn=0 one edge later; ECM_req drops -> BGHn=1 one edge later.
REQ-038 T_RSTn pulsed low in OWN with CORE_gnt=1 -> CORE_gnt=0 and OWNER=00 immediately; state IDLE.
REQ-039 CYC_end pulsed in IDLE/HOLD -> no state or output change.
